// File: rtl/shift_rot_pkg.sv
// Shared types for the shift/rotate register: burst mode and FSM state encodings.
// Mode values match the 2-bit command field issued by the control FSM.
package shift_rot_pkg;

    typedef enum logic [1:0] {
        ROL = 2'b00,
        ROR = 2'b01,
        SHL = 2'b10,
        SHR = 2'b11
    } mode_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/shift_rot_reg_if.sv
// Command/status bundle between the burst-issuing controller and shift_rot_reg.
// The master drives commands and serial fill; the slave returns the register state.
interface shift_rot_reg_if
    import shift_rot_pkg::*;
#(
    parameter int WIDTH = 8
);
    localparam int CW = $clog2(WIDTH + 1);

    logic             load_en;
    logic [WIDTH-1:0] load_val;
    logic             start;
    mode_t            mode;
    logic [CW-1:0]    count;
    logic             ser_in;
    logic [WIDTH-1:0] op;
    logic             ser_out;
    logic             busy;
    logic             done;

    modport master (
        output load_en, load_val, start, mode, count, ser_in,
        input  op, ser_out, busy, done
    );

    modport slave (
        input  load_en, load_val, start, mode, count, ser_in,
        output op, ser_out, busy, done
    );

endinterface

// File: rtl/shift_rot_step.sv
// Single-bit shift/rotate step: returns the next register value and the bit
// pushed out (or wrapped around) by that step.
module shift_rot_step
    import shift_rot_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] value,
    input  mode_t            mode,
    input  logic             fill,
    output logic [WIDTH-1:0] next_value,
    output logic             ejected
);

    always_comb begin
        next_value = value;
        ejected    = 1'b0;
        unique case (mode)
            ROL: begin
                next_value = {value[WIDTH-2:0], value[WIDTH-1]};
                ejected    = value[WIDTH-1];
            end
            ROR: begin
                next_value = {value[0], value[WIDTH-1:1]};
                ejected    = value[0];
            end
            SHL: begin
                next_value = {value[WIDTH-2:0], fill};
                ejected    = value[WIDTH-1];
            end
            SHR: begin
                next_value = {fill, value[WIDTH-1:1]};
                ejected    = value[0];
            end
            default: begin
                next_value = value;
                ejected    = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/shift_rot_reg.sv
// Parametrised shift/rotate register running counted one-bit-per-clock bursts
// with a busy/done handshake; the value holds while idle.
module shift_rot_reg
    import shift_rot_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rstn,
    shift_rot_reg_if.slave   bus
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t           state_q, state_d;
    mode_t            mode_q, mode_d;
    logic [CW-1:0]    rem_q, rem_d;
    logic [WIDTH-1:0] op_q, op_d;
    logic             ser_q, ser_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] step_val;
    logic             step_bit;
    logic             last_step;

    shift_rot_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .value      (op_q),
        .mode       (mode_q),
        .fill       (bus.ser_in),
        .next_value (step_val),
        .ejected    (step_bit)
    );

    assign last_step = (rem_q == CW'(1));

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (!bus.load_en && bus.start && (bus.count != '0)) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (bus.load_en || last_step) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A load always wins: it replaces the value in IDLE and aborts a running burst
    // without a done pulse. A zero-length start completes immediately.
    always_comb begin
        op_d   = op_q;
        ser_d  = ser_q;
        done_d = 1'b0;
        rem_d  = rem_q;
        mode_d = mode_q;
        unique case (state_q)
            IDLE: begin
                if (bus.load_en) begin
                    op_d = bus.load_val;
                end else if (bus.start) begin
                    if (bus.count != '0) begin
                        mode_d = bus.mode;
                        rem_d  = bus.count;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (bus.load_en) begin
                    op_d  = bus.load_val;
                    rem_d = '0;
                end else begin
                    op_d   = step_val;
                    ser_d  = step_bit;
                    rem_d  = rem_q - CW'(1);
                    done_d = last_step;
                end
            end
            default: begin
                rem_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            op_q   <= '0;
            ser_q  <= 1'b0;
            done_q <= 1'b0;
            rem_q  <= '0;
            mode_q <= ROL;
        end else begin
            op_q   <= op_d;
            ser_q  <= ser_d;
            done_q <= done_d;
            rem_q  <= rem_d;
            mode_q <= mode_d;
        end
    end

    assign bus.op      = op_q;
    assign bus.ser_out = ser_q;
    assign bus.done    = done_q;
    assign bus.busy    = (state_q == RUN);

endmodule

// File: doc/shift_rot_reg.md
# shift_rot_reg

Parametrised successor to the fixed 8-bit left-rotating register. Holds a WIDTH-bit value that can be parallel-loaded, and performs counted multi-cycle shift/rotate bursts in one of four modes, one bit position per clock, with a busy/done handshake and a serial in/out path. It sits between a control FSM issuing burst commands and a serial datapath consuming `ser_out`. The register holds its value when idle rather than free-running.

## Interface
- WIDTH, 8, register width in bits; must be ≥ 2.
- CW, $clog2(WIDTH+1), width of the `count` input; derived, not overridden.
- clk  input  1  clock; all state updates on the rising edge.
- rstn  input  1  reset, synchronous, active-low; clock clk.
- load_en  input  1  parallel load request.
- load_val  input  WIDTH  value loaded when `load_en` = 1.
- start  input  1  burst request; sampled only in IDLE.
- mode  input  2  burst mode, latched at start:
  - 00 ROL: rotate left
  - 01 ROR: rotate right
  - 10 SHL: shift left, `ser_in` enters bit 0
  - 11 SHR: shift right, `ser_in` enters bit WIDTH-1
- count  input  CW  number of single-bit steps in the burst; latched at start.
- ser_in  input  1  serial fill bit; sampled at every step edge in SHL/SHR.
- op  output  WIDTH  register value.
- ser_out  output  1  registered copy of the bit that left the register (or wrapped) on the most recent step.
- busy  output  1  high while a burst is running (state RUN).
- done  output  1  one-cycle pulse when a burst completes normally.

## Operation
- States: IDLE, RUN. State encoding and mode encoding are defined in the package.
- Reset (rstn = 0 at an edge):
  - `op` = 0, `ser_out` = 0, `busy` = 0, `done` = 0.
  - State returns to IDLE and the remaining count clears.
  - Reset overrides every other input and aborts any burst in progress.
- IDLE:
  - `load_en` = 1: `op` <= `load_val`. `load_en` has priority over a simultaneous `start`; that `start` is dropped.
  - `start` = 1, `count` ≥ 1: latch `mode`; remaining <= `count`; go to RUN. `op` does not change on this edge.
  - `start` = 1, `count` = 0: no state change; `done` pulses on the next cycle; `op` unchanged.
  - Otherwise `op` holds.
- RUN, each edge:
  - `load_en` = 1: `op` <= `load_val`; burst aborted; go to IDLE; no `done` pulse.
  - Otherwise perform one step in the latched mode:
    - ROL: `op` <= {op[W-2:0], op[W-1]}; `ser_out` <= op[W-1].
    - ROR: `op` <= {op[0], op[W-1:1]}; `ser_out` <= op[0].
    - SHL: `op` <= {op[W-2:0], ser_in}; `ser_out` <= op[W-1].
    - SHR: `op` <= {ser_in, op[W-1:1]}; `ser_out` <= op[0].
  - Decrement remaining on each step. On the step where remaining = 1: go to IDLE and set `done` <= 1.
- Changes to `start`, `mode` and `count` during RUN are ignored. `ser_in` is sampled live at every step edge.
- Counts greater than WIDTH are legal: rotates wrap naturally, and shifts fully flush the register with `ser_in` bits.
- `done` is high for exactly one cycle and is cleared on the following edge.

## Timing
- Start accepted at edge k → `busy` = 1 after edge k; steps occur at edges k+1 … k+N.
- After edge k+N: `busy` = 0 and `done` = 1 for one cycle.
- A new `start` can be accepted at edge k+N+1, so back-to-back bursts have a 1-cycle gap.
- Latency from start to done is N+1 cycles; for `count` = 0 it is 1 cycle.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Package `shift_rot_pkg`: mode enum (ROL, ROR, SHL, SHR), state enum (IDLE, RUN).
- One combinational sub-module, `shift_rot_step` (parameter WIDTH):
  - inputs: value, mode, fill bit
  - outputs: next value, ejected bit
- The top level holds the FSM, the remaining-count register and the output registers.

## Test plan
All scenarios use WIDTH = 8.
- Reset: drive values, then hold rstn = 0 for one edge → `op` = 0x00, `busy` = 0, `done` = 0, `ser_out` = 0.
- ROL wrap: load 0x81; start, mode = 00, count = 3 → `op` sequence 0x03, 0x06, 0x0C; `busy` high for 3 cycles; `done` pulses once; `ser_out` ends at 0.
- SHR serial fill: load 0xF0; mode = 11, count = 4, `ser_in` = 1,0,1,1 → final `op` = 0xDF (0xF8, 0x7C, 0xBE, 0xDF); `ser_out` = 0.
- Edge counts:
  - count = 0 → `done` after 1 cycle, `op` unchanged.
  - count = 9 with ROR on 0x01 → `op` = 0x80.
- Abort and priority:
  - `load_en` = 0x55 at the 2nd step of a 5-step burst → `op` = 0x55, IDLE, no `done`.
  - Simultaneous `load_en` and `start` in IDLE → load only, `busy` stays 0.
- Reset mid-burst (rstn = 0 at step 2) → `op` = 0, `busy` = 0, no `done`; `start` ignored while `busy` = 1.
